// File: rtl/vga_sprite_display_module_pkg.sv
// Shared VGA constants for the sprite display stage: visible timing, RGB565
// layout and the background / transparency colours.
package vga_defs;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;

    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;

    localparam logic [15:0] BG_COLOR  = 16'h001F;
    localparam logic [15:0] KEY_COLOR = 16'hF81F;

    typedef logic [R_W+G_W+B_W-1:0] rgb565_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

endpackage

// File: rtl/vga_sprite_display_module_if.sv
// Sprite ROM bus: address out, RGB565 word back one clock later.
interface vga_sprite_display_module_if;
    logic [11:0] rom_addr;
    logic [15:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/vga_sprite_display_module_sprite_pos_ctrl.sv
// Per-frame bounce controller: each axis steps by STEP on frame_tick and
// clamps to the screen edge for exactly one frame before reversing.
module sprite_pos_ctrl #(
    parameter int H_ACTIVE = vga_defs::H_ACTIVE,
    parameter int V_ACTIVE = vga_defs::V_ACTIVE,
    parameter int SPR_W    = 64,
    parameter int SPR_H    = 64,
    parameter int STEP     = 2
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        frame_tick,
    output logic [10:0] spr_x,
    output logic [10:0] spr_y
);
    import vga_defs::*;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_axis
        localparam int LIMIT = (gi == 0) ? (H_ACTIVE - SPR_W) : (V_ACTIVE - SPR_H);

        logic [10:0] pos_reg, pos_next;
        dir_e        dir_reg, dir_next;

        always_ff @(posedge vga_clk) begin
            if (rst) begin
                pos_reg <= '0;
                dir_reg <= DIR_POS;
            end else begin
                pos_reg <= pos_next;
                dir_reg <= dir_next;
            end
        end

        // 12-bit sum so pos+STEP cannot wrap before the limit compare
        always_comb begin
            pos_next = pos_reg;
            dir_next = dir_reg;
            if (frame_tick) begin
                unique case (dir_reg)
                    DIR_POS: begin
                        if (({1'b0, pos_reg} + 12'(STEP)) >= 12'(LIMIT)) begin
                            pos_next = 11'(LIMIT);
                            dir_next = DIR_NEG;
                        end else begin
                            pos_next = pos_reg + 11'(STEP);
                        end
                    end
                    DIR_NEG: begin
                        if (pos_reg <= 11'(STEP)) begin
                            pos_next = '0;
                            dir_next = DIR_POS;
                        end else begin
                            pos_next = pos_reg - 11'(STEP);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spr_x = g_axis[0].pos_reg;
    assign spr_y = g_axis[1].pos_reg;

endmodule

// File: rtl/vga_sprite_display_module.sv
// Pixel-colour stage behind the 800x600 sync generator: 3-clock pipeline that
// overlays a bouncing 64x64 ROM sprite on a solid background.
module vga_sprite_display_module #(
    parameter int          H_ACTIVE  = vga_defs::H_ACTIVE,
    parameter int          V_ACTIVE  = vga_defs::V_ACTIVE,
    parameter int          SPR_W     = 64,
    parameter int          SPR_H     = 64,
    parameter int          STEP      = 2,
    parameter logic [15:0] BG_COLOR  = vga_defs::BG_COLOR,
    parameter logic [15:0] KEY_COLOR = vga_defs::KEY_COLOR
) (
    input  logic                               vga_clk,
    input  logic                               rst,
    input  logic                               Ready_Sig,
    input  logic                               HSYNC_Sig,
    input  logic                               VSYNC_Sig,
    input  logic [10:0]                        Column_Addr_Sig,
    input  logic [10:0]                        Row_Addr_Sig,
    vga_sprite_display_module_if.master        rom,
    output logic                               VGA_HSYNC,
    output logic                               VGA_VSYNC,
    output logic [4:0]                         VGA_RED,
    output logic [5:0]                         VGA_GREEN,
    output logic [4:0]                         VGA_BLUE,
    output logic                               frame_tick
);
    import vga_defs::*;

    localparam int CB = $clog2(SPR_W);
    localparam int RB = $clog2(SPR_H);

    logic [10:0] spr_x, spr_y;
    logic        vsync_d_reg, frame_tick_reg;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            vsync_d_reg    <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            vsync_d_reg    <= VSYNC_Sig;
            frame_tick_reg <= vsync_d_reg && !VSYNC_Sig;
        end
    end

    sprite_pos_ctrl #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .SPR_W    (SPR_W),
        .SPR_H    (SPR_H),
        .STEP     (STEP)
    ) u_pos (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .frame_tick (frame_tick_reg),
        .spr_x      (spr_x),
        .spr_y      (spr_y)
    );

    // Stage 0: hit test in 12 bits so spr_x+SPR_W at the right edge cannot wrap
    logic [11:0]   col_w, row_w, sx_w, sy_w;
    logic [CB-1:0] col_off;
    logic [RB-1:0] row_off;
    logic          in_spr;

    assign col_w   = {1'b0, Column_Addr_Sig};
    assign row_w   = {1'b0, Row_Addr_Sig};
    assign sx_w    = {1'b0, spr_x};
    assign sy_w    = {1'b0, spr_y};
    assign col_off = Column_Addr_Sig[CB-1:0] - spr_x[CB-1:0];
    assign row_off = Row_Addr_Sig[RB-1:0] - spr_y[RB-1:0];
    assign in_spr  = Ready_Sig
                     && (col_w >= sx_w) && (col_w < sx_w + 12'(SPR_W))
                     && (row_w >= sy_w) && (row_w < sy_w + 12'(SPR_H));

    logic [11:0] rom_addr_reg;
    logic        rdy1_reg, spr1_reg, hs1_reg, vs1_reg;
    logic        rdy2_reg, spr2_reg, hs2_reg, vs2_reg;
    rgb565_t     rgb_reg;
    logic        hs3_reg, vs3_reg;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            rom_addr_reg <= '0;
            rdy1_reg     <= 1'b0;
            spr1_reg     <= 1'b0;
            hs1_reg      <= 1'b1;
            vs1_reg      <= 1'b1;
            rdy2_reg     <= 1'b0;
            spr2_reg     <= 1'b0;
            hs2_reg      <= 1'b1;
            vs2_reg      <= 1'b1;
            rgb_reg      <= '0;
            hs3_reg      <= 1'b1;
            vs3_reg      <= 1'b1;
        end else begin
            rom_addr_reg <= in_spr ? 12'({row_off, col_off}) : 12'd0;
            rdy1_reg     <= Ready_Sig;
            spr1_reg     <= in_spr;
            hs1_reg      <= HSYNC_Sig;
            vs1_reg      <= VSYNC_Sig;
            rdy2_reg     <= rdy1_reg;
            spr2_reg     <= spr1_reg;
            hs2_reg      <= hs1_reg;
            vs2_reg      <= vs1_reg;
            // rom_data answers the address issued one stage earlier
            if (!rdy2_reg)
                rgb_reg <= '0;
            else if (spr2_reg && rom.rom_data != KEY_COLOR)
                rgb_reg <= rom.rom_data;
            else
                rgb_reg <= BG_COLOR;
            hs3_reg      <= hs2_reg;
            vs3_reg      <= vs2_reg;
        end
    end

    assign rom.rom_addr = rom_addr_reg;
    assign VGA_RED      = rgb_reg[R_W+G_W+B_W-1 -: R_W];
    assign VGA_GREEN    = rgb_reg[G_W+B_W-1 -: G_W];
    assign VGA_BLUE     = rgb_reg[B_W-1:0];
    assign VGA_HSYNC    = hs3_reg;
    assign VGA_VSYNC    = vs3_reg;
    assign frame_tick   = frame_tick_reg;

endmodule

// File: tb/tb_vga_sprite_display_module.sv
// Directed bench for the sprite display stage: pipeline latency/alignment,
// transparency, bounce sequence, edge clipping, frame tick and mid-frame reset.
module tb_vga_sprite_display_module;
    import vga_defs::*;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic        Ready_Sig, HSYNC_Sig, VSYNC_Sig;
    logic [10:0] Column_Addr_Sig, Row_Addr_Sig;
    logic        VGA_HSYNC, VGA_VSYNC, frame_tick;
    logic [4:0]  VGA_RED;
    logic [5:0]  VGA_GREEN;
    logic [4:0]  VGA_BLUE;

    vga_sprite_display_module_if rom_if ();

    vga_sprite_display_module dut (
        .vga_clk         (vga_clk),
        .rst             (rst),
        .Ready_Sig       (Ready_Sig),
        .HSYNC_Sig       (HSYNC_Sig),
        .VSYNC_Sig       (VSYNC_Sig),
        .Column_Addr_Sig (Column_Addr_Sig),
        .Row_Addr_Sig    (Row_Addr_Sig),
        .rom             (rom_if),
        .VGA_HSYNC       (VGA_HSYNC),
        .VGA_VSYNC       (VGA_VSYNC),
        .VGA_RED         (VGA_RED),
        .VGA_GREEN       (VGA_GREEN),
        .VGA_BLUE        (VGA_BLUE),
        .frame_tick      (frame_tick)
    );

    always #5 vga_clk = ~vga_clk;

    // Synchronous ROM: data = address, except one transparent word at (10,10)
    always @(posedge vga_clk)
        rom_if.rom_data <= (rom_if.rom_addr == 12'h28A) ? 16'hF81F : {4'h0, rom_if.rom_addr};

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;

    always @(posedge vga_clk)
        if (frame_tick) tick_cnt <= tick_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    logic [15:0] rgb_obs;
    assign rgb_obs = {VGA_RED, VGA_GREEN, VGA_BLUE};

    // Directed pixel vectors and their hand-computed expectations
    int          n_vec = 0;
    logic        v_rdy [32];
    logic        v_hs  [32];
    logic [10:0] v_col [32];
    logic [10:0] v_row [32];
    logic [11:0] e_addr[32];
    logic [15:0] e_rgb [32];

    task automatic add_vec(input logic rdy, input logic hs, input int col, input int row,
                           input logic [11:0] ea, input logic [15:0] er);
        v_rdy[n_vec]  = rdy;
        v_hs[n_vec]   = hs;
        v_col[n_vec]  = 11'(col);
        v_row[n_vec]  = 11'(row);
        e_addr[n_vec] = ea;
        e_rgb[n_vec]  = er;
        n_vec++;
    endtask

    task automatic drive_idle();
        Ready_Sig       = 1'b0;
        HSYNC_Sig       = 1'b1;
        VSYNC_Sig       = 1'b1;
        Column_Addr_Sig = '0;
        Row_Addr_Sig    = '0;
    endtask

    // One vector per clock; rom_addr checked 1 clock later, RGB/hsync 3 clocks later
    task automatic run_stream(input string name);
        for (int i = 0; i < n_vec + 3; i++) begin
            @(negedge vga_clk);
            if (i >= 1 && i - 1 < n_vec)
                check_val($sformatf("%s_addr%0d", name, i - 1), 32'(rom_if.rom_addr), 32'(e_addr[i-1]));
            if (i >= 3) begin
                check_val($sformatf("%s_rgb%0d", name, i - 3), 32'(rgb_obs), 32'(e_rgb[i-3]));
                check_val($sformatf("%s_hs%0d", name, i - 3), 32'(VGA_HSYNC), 32'(v_hs[i-3]));
            end
            if (i < n_vec) begin
                Ready_Sig       = v_rdy[i];
                HSYNC_Sig       = v_hs[i];
                Column_Addr_Sig = v_col[i];
                Row_Addr_Sig    = v_row[i];
            end else begin
                drive_idle();
            end
        end
        n_vec = 0;
    endtask

    int   mx = 0, my = 0;
    logic mdx = 1'b0, mdy = 1'b0;
    int   max_x = 0, max_y = 0;

    task automatic model_step();
        if (!mdx) begin
            if (mx + 2 >= 736) begin mx = 736; mdx = 1'b1; end else mx = mx + 2;
        end else begin
            if (mx <= 2) begin mx = 0; mdx = 1'b0; end else mx = mx - 2;
        end
        if (!mdy) begin
            if (my + 2 >= 536) begin my = 536; mdy = 1'b1; end else my = my + 2;
        end else begin
            if (my <= 2) begin my = 0; mdy = 1'b0; end else my = my - 2;
        end
    endtask

    // Compressed frame: short vsync low pulse with blanking throughout
    task automatic do_frame(input int f);
        int old_x, old_y;
        old_x = mx;
        old_y = my;
        @(negedge vga_clk);
        VSYNC_Sig = 1'b0;
        @(negedge vga_clk);
        check_val($sformatf("tick_f%0d", f), 32'(frame_tick), 32'd1);
        check_val($sformatf("hold_x_f%0d", f), 32'(dut.u_pos.spr_x), 32'(old_x));
        model_step();
        @(negedge vga_clk);
        check_val($sformatf("tick_end_f%0d", f), 32'(frame_tick), 32'd0);
        check_val($sformatf("pos_x_f%0d", f), 32'(dut.u_pos.spr_x), 32'(mx));
        check_val($sformatf("pos_y_f%0d", f), 32'(dut.u_pos.spr_y), 32'(my));
        @(negedge vga_clk);
        VSYNC_Sig = 1'b1;
        repeat (3) @(negedge vga_clk);
        if (32'(dut.u_pos.spr_x) > max_x) max_x = int'(dut.u_pos.spr_x);
        if (32'(dut.u_pos.spr_y) > max_y) max_y = int'(dut.u_pos.spr_y);
    endtask

    task automatic edge_test(input string name);
        add_vec(1'b1, 1'b1, mx + 63, my + 63, 12'hFFF, 16'h0FFF);
        add_vec(1'b1, 1'b1, mx + 62, my + 63, 12'hFFE, 16'h0FFE);
        add_vec(1'b1, 1'b1, mx, my, 12'h000, 16'h0000);
        add_vec(1'b1, 1'b1, 0, 0, 12'h000, BG_COLOR);
        add_vec(1'b0, 1'b0, 0, 0, 12'h000, 16'h0000);
        run_stream(name);
    endtask

    initial begin
        logic done_x, done_y;
        done_x = 1'b0;
        done_y = 1'b0;
        rst = 1'b1;
        drive_idle();
        repeat (4) @(negedge vga_clk);
        check_val("rst_rgb", 32'(rgb_obs), 32'd0);
        check_val("rst_hs", 32'(VGA_HSYNC), 32'd1);
        check_val("rst_vs", 32'(VGA_VSYNC), 32'd1);
        check_val("rst_addr", 32'(rom_if.rom_addr), 32'd0);
        check_val("rst_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;

        // Sprite at (0,0): latency, transparency, outside and blanking
        add_vec(1'b1, 1'b1, 5, 3, 12'h0C5, 16'h00C5);
        add_vec(1'b1, 1'b1, 10, 10, 12'h28A, BG_COLOR);
        add_vec(1'b1, 1'b1, 64, 0, 12'h000, BG_COLOR);
        add_vec(1'b0, 1'b1, 5, 3, 12'h000, 16'h0000);
        add_vec(1'b0, 1'b0, 0, 0, 12'h000, 16'h0000);
        add_vec(1'b0, 1'b0, 0, 0, 12'h000, 16'h0000);
        add_vec(1'b1, 1'b1, 63, 63, 12'hFFF, 16'h0FFF);
        add_vec(1'b1, 1'b1, 0, 64, 12'h000, BG_COLOR);
        add_vec(1'b1, 1'b1, 0, 0, 12'h000, 16'h0000);
        add_vec(1'b1, 1'b1, 1, 0, 12'h001, 16'h0001);
        run_stream("origin");

        for (int f = 1; f <= 400; f++) begin
            do_frame(f);
            if (my == 536 && !done_y) begin
                done_y = 1'b1;
                edge_test("bottom");
            end
            if (mx == 736 && !done_x) begin
                done_x = 1'b1;
                edge_test("right");
            end
        end
        check_val("tick_count", 32'(tick_cnt), 32'd400);
        check_val("final_x", 32'(dut.u_pos.spr_x), 32'd672);
        check_val("final_y", 32'(dut.u_pos.spr_y), 32'd272);
        check_val("max_x", 32'(max_x), 32'd736);
        check_val("max_y", 32'(max_y), 32'd536);

        // Mid-line reset while a sprite pixel with low hsync is in flight
        @(negedge vga_clk);
        Ready_Sig       = 1'b1;
        HSYNC_Sig       = 1'b0;
        Column_Addr_Sig = 11'(mx + 5);
        Row_Addr_Sig    = 11'(my + 3);
        repeat (3) @(negedge vga_clk);
        check_val("pre_rst_rgb", 32'(rgb_obs), 32'h00C5);
        check_val("pre_rst_hs", 32'(VGA_HSYNC), 32'd0);
        rst = 1'b1;
        @(negedge vga_clk);
        check_val("mid_rst_rgb", 32'(rgb_obs), 32'd0);
        check_val("mid_rst_hs", 32'(VGA_HSYNC), 32'd1);
        check_val("mid_rst_vs", 32'(VGA_VSYNC), 32'd1);
        check_val("mid_rst_addr", 32'(rom_if.rom_addr), 32'd0);
        repeat (4) @(negedge vga_clk);
        check_val("mid_rst_x", 32'(dut.u_pos.spr_x), 32'd0);
        check_val("mid_rst_y", 32'(dut.u_pos.spr_y), 32'd0);
        drive_idle();
        rst = 1'b0;
        mx = 0; my = 0; mdx = 1'b0; mdy = 1'b0;

        add_vec(1'b0, 1'b1, 0, 0, 12'h000, 16'h0000);
        add_vec(1'b1, 1'b1, 5, 3, 12'h0C5, 16'h00C5);
        add_vec(1'b1, 1'b1, 10, 10, 12'h28A, BG_COLOR);
        run_stream("post_rst");
        do_frame(401);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
